// File: rtl/ex_pkg.sv
// Shared execute-stage encodings: ALU opcodes and operand-select codes,
// also consumed by the ALU and the decoder.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    localparam logic [1:0] OPA_RS1   = 2'b00;
    localparam logic [1:0] OPA_PC    = 2'b01;
    localparam logic [1:0] OPA_ZERO  = 2'b10;
    localparam logic [1:0] OPA_ZERO2 = 2'b11;

    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Bypass select for one source register: EX, then MEM, then WB, else RF.
// Purely combinational; x0 never matches a producer.
module fwd_mux
    import ex_pkg::*;
(
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_rf_data,
    input  logic        i_ex_en,
    input  logic [4:0]  i_ex_rd,
    input  logic [31:0] i_ex_data,
    input  logic [4:0]  i_mem_rd,
    input  logic [31:0] i_mem_data,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_addr != 5'd0) begin
            if (i_ex_en && (i_ex_rd == i_addr)) begin
                o_data = i_ex_data;
            end else if (i_mem_rd == i_addr) begin
                o_data = i_mem_data;
            end else if (i_wb_rd == i_addr) begin
                o_data = i_wb_data;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX operand register with bypassing; one-cycle latency.
// Stalls upstream (comb o_stall) for one cycle on load-use; flush wins over stall.
module ex_operand_stage
    import ex_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_id_valid,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_alu_op,
    input  logic [1:0]  i_opa_sel,
    input  logic        i_opb_sel,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [31:0] i_ex_data,
    input  logic [4:0]  i_mem_rd_addr,
    input  logic [31:0] i_mem_data,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_op_a,
    output logic [31:0] o_op_b,
    output logic [3:0]  o_alu_op,
    output logic [4:0]  o_rd_addr,
    output logic        o_is_load,
    output logic [31:0] o_store_data
);

    logic        valid_q, valid_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_load_q, is_load_d;
    logic [31:0] store_q, store_d;

    logic        rs1_used, rs2_used, hazard, bubble, ex_fwd_en;
    logic [31:0] rs1_fwd, rs2_fwd;

    assign rs1_used = i_id_valid && (i_opa_sel == OPA_RS1) && (i_rs1_addr != 5'd0);
    assign rs2_used = i_id_valid && ((i_opb_sel == OPB_RS2) || i_is_store) && (i_rs2_addr != 5'd0);

    assign hazard = valid_q && is_load_q && (rd_q != 5'd0) &&
                    ((rs1_used && (i_rs1_addr == rd_q)) || (rs2_used && (i_rs2_addr == rd_q)));
    assign o_stall = hazard && !i_flush;
    assign bubble  = i_flush || hazard || !i_id_valid;

    // A load's data is not ready in EX, so only ALU results bypass from there.
    assign ex_fwd_en = valid_q && !is_load_q;

    fwd_mux u_fwd_rs1 (
        .i_addr     (i_rs1_addr),
        .i_rf_data  (i_rs1_data),
        .i_ex_en    (ex_fwd_en),
        .i_ex_rd    (rd_q),
        .i_ex_data  (i_ex_data),
        .i_mem_rd   (i_mem_rd_addr),
        .i_mem_data (i_mem_data),
        .i_wb_rd    (i_wb_rd_addr),
        .i_wb_data  (i_wb_data),
        .o_data     (rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .i_addr     (i_rs2_addr),
        .i_rf_data  (i_rs2_data),
        .i_ex_en    (ex_fwd_en),
        .i_ex_rd    (rd_q),
        .i_ex_data  (i_ex_data),
        .i_mem_rd   (i_mem_rd_addr),
        .i_mem_data (i_mem_data),
        .i_wb_rd    (i_wb_rd_addr),
        .i_wb_data  (i_wb_data),
        .o_data     (rs2_fwd)
    );

    always_comb begin
        valid_d   = 1'b0;
        op_a_d    = 32'd0;
        op_b_d    = 32'd0;
        alu_op_d  = ALU_ADD;
        rd_d      = 5'd0;
        is_load_d = 1'b0;
        store_d   = 32'd0;
        if (!bubble) begin
            valid_d   = 1'b1;
            alu_op_d  = i_alu_op;
            rd_d      = i_rd_addr;
            is_load_d = i_is_load;
            store_d   = rs2_fwd;
            op_b_d    = (i_opb_sel == OPB_IMM) ? i_imm : rs2_fwd;
            case (i_opa_sel)
                OPA_RS1: op_a_d = rs1_fwd;
                OPA_PC:  op_a_d = i_pc;
                default: op_a_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            alu_op_q  <= 4'd0;
            rd_q      <= 5'd0;
            is_load_q <= 1'b0;
            store_q   <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            alu_op_q  <= alu_op_d;
            rd_q      <= rd_d;
            is_load_q <= is_load_d;
            store_q   <= store_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_op_a       = op_a_q;
    assign o_op_b       = op_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_rd_addr    = rd_q;
    assign o_is_load    = is_load_q;
    assign o_store_data = store_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios plus random traffic
// against a behavioural next-state model.
module tb_ex_operand_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_id_valid;
    logic [4:0]  i_rs1_addr, i_rs2_addr;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_pc;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_opa_sel;
    logic        i_opb_sel;
    logic [4:0]  i_rd_addr;
    logic        i_is_load, i_is_store;
    logic [31:0] i_ex_data;
    logic [4:0]  i_mem_rd_addr;
    logic [31:0] i_mem_data;
    logic [4:0]  i_wb_rd_addr;
    logic [31:0] i_wb_data;
    logic        i_flush;
    logic        o_stall, o_valid, o_is_load;
    logic [31:0] o_op_a, o_op_b, o_store_data;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd_addr;

    ex_operand_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_pc(i_pc), .i_alu_op(i_alu_op),
        .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel), .i_rd_addr(i_rd_addr),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_ex_data(i_ex_data),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_data(i_mem_data),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_data(i_wb_data), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_alu_op(o_alu_op), .o_rd_addr(o_rd_addr), .o_is_load(o_is_load),
        .o_store_data(o_store_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic last_stall;

    // Model of what the EX stage should currently hold.
    logic        m_valid, m_is_load;
    logic [4:0]  m_rd;
    logic [3:0]  m_alu;
    logic [31:0] m_opa, m_opb, m_sd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
        logic [4:0]  rds [3];
        logic [31:0] ds  [3];
        logic        ok  [3];
        rds = '{m_rd, i_mem_rd_addr, i_wb_rd_addr};
        ds  = '{i_ex_data, i_mem_data, i_wb_data};
        ok  = '{m_valid && !m_is_load, 1'b1, 1'b1};
        if (a == 5'd0) return rf;
        for (int k = 0; k < 3; k++)
            if (ok[k] && rds[k] == a) return ds[k];
        return rf;
    endfunction

    function automatic logic m_stall();
        logic u1, u2;
        u1 = i_id_valid && i_opa_sel == 2'b00 && i_rs1_addr != 0;
        u2 = i_id_valid && (i_opb_sel == 1'b0 || i_is_store) && i_rs2_addr != 0;
        return m_valid && m_is_load && m_rd != 0 && !i_flush &&
               ((u1 && i_rs1_addr == m_rd) || (u2 && i_rs2_addr == m_rd));
    endfunction

    task automatic m_reset();
        m_valid = 0; m_is_load = 0; m_rd = 0; m_alu = 0; m_opa = 0; m_opb = 0; m_sd = 0;
    endtask

    task automatic compare_outputs();
        chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
        chk("o_op_a", o_op_a, m_opa);
        chk("o_op_b", o_op_b, m_opb);
        chk("o_alu_op", {28'd0, o_alu_op}, {28'd0, m_alu});
        chk("o_rd_addr", {27'd0, o_rd_addr}, {27'd0, m_rd});
        chk("o_is_load", {31'd0, o_is_load}, {31'd0, m_is_load});
        chk("o_store_data", o_store_data, m_sd);
    endtask

    // Entered just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        logic        st;
        logic [31:0] f1, f2;
        #1;
        st = m_stall();
        chk("o_stall", {31'd0, o_stall}, {31'd0, st});
        last_stall = o_stall;
        f1 = m_fwd(i_rs1_addr, i_rs1_data);
        f2 = m_fwd(i_rs2_addr, i_rs2_data);
        @(posedge i_clk);
        if (i_flush || st || !i_id_valid) begin
            m_reset();
        end else begin
            m_valid = 1; m_rd = i_rd_addr; m_is_load = i_is_load; m_alu = i_alu_op;
            m_sd = f2;
            m_opb = i_opb_sel ? i_imm : f2;
            m_opa = (i_opa_sel == 2'b00) ? f1 : (i_opa_sel == 2'b01) ? i_pc : 32'd0;
        end
        #1;
        compare_outputs();
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_id_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_data = 0; i_rs2_data = 0;
        i_imm = 0; i_pc = 0; i_alu_op = 0; i_opa_sel = 0; i_opb_sel = 0; i_rd_addr = 0;
        i_is_load = 0; i_is_store = 0; i_ex_data = 0; i_mem_rd_addr = 0; i_mem_data = 0;
        i_wb_rd_addr = 0; i_wb_data = 0; i_flush = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] asel,
                         input logic bsel, input logic [31:0] imm, input logic [4:0] rd,
                         input logic ld);
        i_id_valid = 1; i_rs1_addr = rs1; i_rs2_addr = rs2; i_opa_sel = asel;
        i_opb_sel = bsel; i_imm = imm; i_rd_addr = rd; i_is_load = ld; i_alu_op = 4'b0000;
    endtask

    initial begin
        idle();
        m_reset();
        last_stall = 0;
        i_rst_n = 0;
        #3;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_op_a", o_op_a, 32'd0);
        chk("reset_stall", {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1;

        // addi x1,x0,5 ; add x2,x1,x1 -> EX forward, no stall
        instr(5'd0, 5'd0, 2'b00, 1'b1, 32'd5, 5'd1, 1'b0);
        cycle();
        chk("addi_op_b", o_op_b, 32'd5);
        instr(5'd1, 5'd1, 2'b00, 1'b0, 32'd0, 5'd2, 1'b0);
        i_rs1_data = 32'hDEAD; i_rs2_data = 32'hDEAD; i_ex_data = 32'd5;
        cycle();
        chk("b2b_stall", {31'd0, last_stall}, 32'd0);
        chk("b2b_op_a", o_op_a, 32'd5);
        chk("b2b_op_b", o_op_b, 32'd5);

        // lw x3 ; add x4,x3,x0 -> one bubble then MEM forward
        idle();
        instr(5'd0, 5'd0, 2'b00, 1'b1, 32'd0, 5'd3, 1'b1);
        cycle();
        instr(5'd3, 5'd0, 2'b00, 1'b0, 32'd0, 5'd4, 1'b0);
        i_ex_data = 32'h9999;
        cycle();
        chk("lu_stall", {31'd0, last_stall}, 32'd1);
        chk("lu_bubble", {31'd0, o_valid}, 32'd0);
        i_mem_rd_addr = 5'd3; i_mem_data = 32'h1234;
        cycle();
        chk("lu_stall2", {31'd0, last_stall}, 32'd0);
        chk("lu_op_a", o_op_a, 32'h1234);
        chk("lu_rd", {27'd0, o_rd_addr}, 32'd4);

        // MEM and WB both target x5 -> MEM wins
        idle();
        instr(5'd5, 5'd0, 2'b00, 1'b1, 32'd0, 5'd6, 1'b0);
        i_mem_rd_addr = 5'd5; i_mem_data = 32'hA; i_wb_rd_addr = 5'd5; i_wb_data = 32'hB;
        cycle();
        chk("memwb_op_a", o_op_a, 32'hA);

        // Reset mid-stream with o_valid=1
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        idle();
        #2 i_rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_op_a", o_op_a, 32'd0);
        chk("arst_rd", {27'd0, o_rd_addr}, 32'd0);
        chk("arst_stall", {31'd0, o_stall}, 32'd0);
        m_reset();
        i_rst_n = 1;
        cycle();

        // Producer with rd=0 (load, EX value 0xFFFF) -> no stall, RF value used
        instr(5'd0, 5'd0, 2'b00, 1'b1, 32'd0, 5'd0, 1'b1);
        cycle();
        instr(5'd0, 5'd0, 2'b00, 1'b0, 32'd0, 5'd7, 1'b0);
        i_ex_data = 32'hFFFF;
        cycle();
        chk("x0_stall", {31'd0, last_stall}, 32'd0);
        chk("x0_op_a", o_op_a, 32'd0);

        // Flush together with a load-use hazard
        idle();
        instr(5'd0, 5'd0, 2'b00, 1'b1, 32'd0, 5'd3, 1'b1);
        cycle();
        instr(5'd3, 5'd0, 2'b00, 1'b0, 32'd0, 5'd4, 1'b0);
        i_flush = 1;
        cycle();
        chk("flush_stall", {31'd0, last_stall}, 32'd0);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_rd", {27'd0, o_rd_addr}, 32'd0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            i_id_valid    = ($urandom % 4) != 0;
            i_rs1_addr    = 5'($urandom_range(0, 3));
            i_rs2_addr    = 5'($urandom_range(0, 3));
            i_rs1_data    = $urandom;
            i_rs2_data    = $urandom;
            i_imm         = $urandom;
            i_pc          = $urandom;
            i_alu_op      = 4'($urandom);
            i_opa_sel     = 2'($urandom);
            i_opb_sel     = 1'($urandom);
            i_rd_addr     = 5'($urandom_range(0, 3));
            i_is_load     = ($urandom % 3) == 0;
            i_is_store    = ($urandom % 4) == 0;
            i_ex_data     = $urandom;
            i_mem_rd_addr = 5'($urandom_range(0, 3));
            i_mem_data    = $urandom;
            i_wb_rd_addr  = 5'($urandom_range(0, 3));
            i_wb_data     = $urandom;
            i_flush       = ($urandom % 8) == 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
